regfile_param: RTL and testbench

Parametrised register file with two registered read ports, one write port and a per-register busy scoreboard. It is the next generation of the single-width 32x32 `RegFile` and sits in the decode/writeback stage of the core datapath. Issue logic reserves a destination register, and writeback both writes the register and releases the reservation. Read ports report each source register's value together with its busy state.

---
 rtl/regfile_param.sv | 116 +++++++++++
 tb/tb_regfile_param.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports, one write port, per-register busy
// scoreboard. Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             readEn,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic [WIDTH-1:0] readOut1,
    output logic [WIDTH-1:0] readOut2,
    output logic             busy1,
    output logic             busy2,
    input  logic             writeEn,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             rsvEn,
    input  logic [AW-1:0]    rsvRd,
    output logic [DEPTH-1:0] busyVec
);

    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] rf_q   [DEPTH];
    logic [WIDTH-1:0] rf_d   [DEPTH];
    logic [WIDTH-1:0] rf_src [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d, busy_src;
    logic [WIDTH-1:0] out1_q, out2_q, rdata1, rdata2;
    logic             b1_q, b2_q, rbusy1, rbusy2;
    logic             wr_ok, rsv_ok;

    // Address maps to a real, writable register (excludes out-of-range and hardwired r0).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DepthW) && !(ZERO_REG && (a == '0));
    endfunction

    always_comb begin
        wr_ok  = en && writeEn && addr_ok(rd);
        rsv_ok = en && rsvEn && addr_ok(rsvRd);
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            rf_d[i] = rf_q[i];
            if (wr_ok && (rd == AW'(i))) begin
                rf_d[i]   = dataIn;
                busy_d[i] = 1'b0;
            end
            // A new reservation supersedes the completing producer.
            if (rsv_ok && (rsvRd == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rf_src   = rf_d;
    assign busy_src = busy_d;
`else
    assign rf_src   = rf_q;
    assign busy_src = busy_q;
`endif

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        rbusy1 = 1'b0;
        rbusy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_ok(AW'(i))) begin
                if (rs1 == AW'(i)) begin
                    rdata1 = rf_src[i];
                    rbusy1 = busy_src[i];
                end
                if (rs2 == AW'(i)) begin
                    rdata2 = rf_src[i];
                    rbusy2 = busy_src[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            busy_q <= '0;
            out1_q <= '0;
            out2_q <= '0;
            b1_q   <= 1'b0;
            b2_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= rf_d[i];
            end
            busy_q <= busy_d;
            if (en && readEn) begin
                out1_q <= rdata1;
                out2_q <= rdata2;
                b1_q   <= rbusy1;
                b2_q   <= rbusy2;
            end
        end
    end

    assign readOut1 = out1_q;
    assign readOut2 = out2_q;
    assign busy1    = b1_q;
    assign busy2    = b2_q;
    assign busyVec  = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: two instances (DEPTH 32 and 24) against an array model.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset, en, readEn, writeEn, rsvEn;
    logic [4:0]  rs1, rs2, rd, rsvRd;
    logic [31:0] dataIn;
    logic [31:0] a_o1, a_o2, b_o1, b_o2;
    logic        a_b1, a_b2, b_b1, b_b2;
    logic [31:0] a_bv;
    logic [23:0] b_bv;
    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .readEn(readEn), .rs1(rs1), .rs2(rs2),
        .readOut1(a_o1), .readOut2(a_o2), .busy1(a_b1), .busy2(a_b2),
        .writeEn(writeEn), .rd(rd), .dataIn(dataIn), .rsvEn(rsvEn), .rsvRd(rsvRd),
        .busyVec(a_bv)
    );

    regfile_param #(.WIDTH(32), .DEPTH(24), .AW(5), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .readEn(readEn), .rs1(rs1), .rs2(rs2),
        .readOut1(b_o1), .readOut2(b_o2), .busy1(b_b1), .busy2(b_b2),
        .writeEn(writeEn), .rd(rd), .dataIn(dataIn), .rsvEn(rsvEn), .rsvRd(rsvRd),
        .busyVec(b_bv)
    );

    // Reference model, index 0 = DEPTH 32, index 1 = DEPTH 24.
    logic [31:0] m_rf   [2][32];
    bit          m_busy [2][32];
    logic [31:0] m_o1 [2];
    logic [31:0] m_o2 [2];
    bit          m_b1 [2];
    bit          m_b2 [2];

    function automatic int depth_of(input int k);
        return (k == 0) ? 32 : 24;
    endfunction

    function automatic logic [31:0] model_bv(input int k);
        logic [31:0] v = '0;
        for (int i = 0; i < depth_of(k); i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[k][i]   = '0;
                m_busy[k][i] = 1'b0;
            end
            m_o1[k] = '0; m_o2[k] = '0; m_b1[k] = 1'b0; m_b2[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int          d = depth_of(k);
            logic [31:0] nrf [32];
            bit          nb  [32];
            bit          wr, rsv;
            for (int i = 0; i < 32; i++) begin
                nrf[i] = m_rf[k][i];
                nb[i]  = m_busy[k][i];
            end
            wr  = en && writeEn && (int'(rd) < d) && (rd != 0);
            rsv = en && rsvEn && (int'(rsvRd) < d) && (rsvRd != 0);
            if (wr) begin
                nrf[rd] = dataIn;
                nb[rd]  = 1'b0;
            end
            if (rsv) nb[rsvRd] = 1'b1;
            if (en && readEn) begin
                if ((int'(rs1) < d) && (rs1 != 0)) begin
                    m_o1[k] = Bypass ? nrf[rs1] : m_rf[k][rs1];
                    m_b1[k] = Bypass ? nb[rs1] : m_busy[k][rs1];
                end else begin
                    m_o1[k] = '0; m_b1[k] = 1'b0;
                end
                if ((int'(rs2) < d) && (rs2 != 0)) begin
                    m_o2[k] = Bypass ? nrf[rs2] : m_rf[k][rs2];
                    m_b2[k] = Bypass ? nb[rs2] : m_busy[k][rs2];
                end else begin
                    m_o2[k] = '0; m_b2[k] = 1'b0;
                end
            end
            for (int i = 0; i < 32; i++) begin
                m_rf[k][i]   = nrf[i];
                m_busy[k][i] = nb[i];
            end
        end
    endtask

    task automatic idle();
        en = 1'b1; readEn = 1'b0; writeEn = 1'b0; rsvEn = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; rsvRd = '0; dataIn = '0;
    endtask

    // Inputs change at posedge+1, so they are stable around the next edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        #1 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({a_o1, a_o2, a_b1, a_b2, a_bv} !== '0) begin
            errors++;
            $display("FAIL reset_init_a got %h want 0", {a_o1, a_o2, a_b1, a_b2, a_bv});
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        for (int i = 1; i < 5; i++) begin
            writeEn = 1'b1; rd = 5'(i); dataIn = $urandom;
            rsvEn = 1'b1; rsvRd = 5'(i + 5);
            readEn = 1'b1; rs1 = 5'(i - 1); rs2 = 5'(i);
            tick();
        end
        idle();
        readEn = 1'b1; rs1 = 5'd2; rs2 = 5'd3;
        tick();
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({a_o1, a_o2, a_b1, a_b2, a_bv} !== '0) begin
            errors++;
            $display("FAIL reset_mid_a got %h want 0", {a_o1, a_o2, a_b1, a_b2, a_bv});
        end
        checks++;
        if ({b_o1, b_o2, b_b1, b_b2, b_bv} !== '0) begin
            errors++;
            $display("FAIL reset_mid_b got %h want 0", {b_o1, b_o2, b_b1, b_b2, b_bv});
        end
        #1 reset = 1'b0;
        @(posedge clk) #1;
        for (int i = 0; i < 32; i += 2) begin
            idle();
            readEn = 1'b1; rs1 = 5'(i); rs2 = 5'(i + 1);
            tick();
            checks++;
            if ({a_o1, a_o2, a_b1, a_b2} !== '0) begin
                errors++;
                $display("FAIL reset_read r%0d got %h want 0", i, {a_o1, a_o2, a_b1, a_b2});
            end
        end
    endtask

    task automatic test_basic();
        idle();
        writeEn = 1'b1; rd = 5'd5; dataIn = 32'hDEADBEEF;
        tick();
        idle();
        readEn = 1'b1; rs1 = 5'd5; rs2 = 5'd5;
        tick();
        checks++;
        if (a_o1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_o1 got %h want deadbeef", a_o1);
        end
        checks++;
        if (a_o2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_o2 got %h want deadbeef", a_o2);
        end
        checks++;
        if (b_o1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL basic_b_o1 got %h want deadbeef", b_o1);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        writeEn = 1'b1; rd = 5'd0; dataIn = 32'h12345678;
        rsvEn = 1'b1; rsvRd = 5'd0;
        tick();
        checks++;
        if (a_bv[0] !== 1'b0) begin
            errors++; $display("FAIL zero_bv0 got %b want 0", a_bv[0]);
        end
        idle();
        readEn = 1'b1; rs1 = 5'd0;
        tick();
        checks++;
        if (a_o1 !== 32'h0 || a_b1 !== 1'b0) begin
            errors++; $display("FAIL zero_read got %h/%b want 0/0", a_o1, a_b1);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsvEn = 1'b1; rsvRd = 5'd7;
        tick();
        checks++;
        if (a_bv[7] !== 1'b1) begin
            errors++; $display("FAIL sb_bv7_set got %b want 1", a_bv[7]);
        end
        idle();
        readEn = 1'b1; rs2 = 5'd7;
        tick();
        checks++;
        if (a_b2 !== 1'b1) begin
            errors++; $display("FAIL sb_busy2 got %b want 1", a_b2);
        end
        idle();
        writeEn = 1'b1; rd = 5'd7; dataIn = 32'hA5A5A5A5;
        tick();
        checks++;
        if (a_bv[7] !== 1'b0) begin
            errors++; $display("FAIL sb_bv7_clr got %b want 0", a_bv[7]);
        end
        idle();
        readEn = 1'b1; rs2 = 5'd7;
        tick();
        checks++;
        if (a_o2 !== 32'hA5A5A5A5 || a_b2 !== 1'b0) begin
            errors++; $display("FAIL sb_r7 got %h/%b want a5a5a5a5/0", a_o2, a_b2);
        end
        idle();
        writeEn = 1'b1; rd = 5'd9; dataIn = 32'h0BADF00D;
        rsvEn = 1'b1; rsvRd = 5'd9;
        tick();
        checks++;
        if (a_bv[9] !== 1'b1) begin
            errors++; $display("FAIL sb_bv9 got %b want 1", a_bv[9]);
        end
        idle();
        readEn = 1'b1; rs1 = 5'd9;
        tick();
        checks++;
        if (a_o1 !== 32'h0BADF00D || a_b1 !== 1'b1) begin
            errors++; $display("FAIL sb_r9 got %h/%b want 0badf00d/1", a_o1, a_b1);
        end
    endtask

    task automatic test_bypass();
        idle();
        writeEn = 1'b1; rd = 5'd3; dataIn = 32'd1;
        tick();
        writeEn = 1'b1; rd = 5'd3; dataIn = 32'd2;
        readEn = 1'b1; rs1 = 5'd3;
        tick();
        checks++;
        if (a_o1 !== (Bypass ? 32'd2 : 32'd1) || a_b1 !== 1'b0) begin
            errors++;
            $display("FAIL bypass_r3 got %h/%b want %h/0", a_o1, a_b1, Bypass ? 32'd2 : 32'd1);
        end
        idle();
        readEn = 1'b1; rs1 = 5'd3;
        tick();
        checks++;
        if (a_o1 !== 32'd2) begin
            errors++; $display("FAIL bypass_after got %h want 2", a_o1);
        end
    endtask

    task automatic test_enable();
        idle();
        writeEn = 1'b1; rd = 5'd4; dataIn = 32'h44;
        tick();
        idle();
        readEn = 1'b1; rs1 = 5'd4; rs2 = 5'd4;
        tick();
        en = 1'b0;
        writeEn = 1'b1; rd = 5'd4; dataIn = 32'h99;
        rsvEn = 1'b1; rsvRd = 5'd4;
        readEn = 1'b1; rs1 = 5'd5; rs2 = 5'd7;
        tick();
        checks++;
        if (a_o1 !== 32'h44 || a_o2 !== 32'h44) begin
            errors++; $display("FAIL en_hold got %h/%h want 44/44", a_o1, a_o2);
        end
        checks++;
        if (a_bv[4] !== 1'b0) begin
            errors++; $display("FAIL en_busy4 got %b want 0", a_bv[4]);
        end
        idle();
        readEn = 1'b1; rs1 = 5'd4;
        tick();
        checks++;
        if (a_o1 !== 32'h44 || a_b1 !== 1'b0) begin
            errors++; $display("FAIL en_r4 got %h/%b want 44/0", a_o1, a_b1);
        end
        idle();
        writeEn = 1'b1; rd = 5'd30; dataIn = 32'h30;
        rsvEn = 1'b1; rsvRd = 5'd30;
        tick();
        checks++;
        if (b_bv !== model_bv(1)[23:0]) begin
            errors++; $display("FAIL oor_bv got %h want %h", b_bv, model_bv(1)[23:0]);
        end
        idle();
        readEn = 1'b1; rs1 = 5'd30;
        tick();
        checks++;
        if (b_o1 !== 32'h0 || b_b1 !== 1'b0) begin
            errors++; $display("FAIL oor_read got %h/%b want 0/0", b_o1, b_b1);
        end
        checks++;
        if (a_o1 !== 32'h30 || a_b1 !== 1'b1) begin
            errors++; $display("FAIL d32_r30 got %h/%b want 30/1", a_o1, a_b1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en      = ($urandom_range(0, 9) != 0);
            readEn  = ($urandom_range(0, 3) != 0);
            writeEn = $urandom_range(0, 1);
            rsvEn   = ($urandom_range(0, 2) == 0);
            rs1     = 5'($urandom_range(0, 31));
            rs2     = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
            rd      = ($urandom_range(0, 2) == 0) ? rs1 : 5'($urandom_range(0, 31));
            rsvRd   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            dataIn  = $urandom;
            tick();
            for (int k = 0; k < 2; k++) begin
                logic [31:0] o1, o2, bv;
                logic        b1, b2;
                o1 = (k == 0) ? a_o1 : b_o1;
                o2 = (k == 0) ? a_o2 : b_o2;
                b1 = (k == 0) ? a_b1 : b_b1;
                b2 = (k == 0) ? a_b2 : b_b2;
                bv = (k == 0) ? a_bv : {8'h0, b_bv};
                checks++;
                if (o1 !== m_o1[k] || b1 !== m_b1[k]) begin
                    errors++;
                    $display("FAIL rand_p1 dut%0d cyc%0d got %h/%b want %h/%b",
                             k, n, o1, b1, m_o1[k], m_b1[k]);
                end
                checks++;
                if (o2 !== m_o2[k] || b2 !== m_b2[k]) begin
                    errors++;
                    $display("FAIL rand_p2 dut%0d cyc%0d got %h/%b want %h/%b",
                             k, n, o2, b2, m_o2[k], m_b2[k]);
                end
                checks++;
                if (bv !== model_bv(k)) begin
                    errors++;
                    $display("FAIL rand_bv dut%0d cyc%0d got %h want %h", k, n, bv, model_bv(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_reg();
        test_scoreboard();
        test_bypass();
        test_enable();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
